// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter:
//   - one-hot state encoding constants and the FSM state type
//   - legal range for the number of requesters and its check function
// Ports: none (package).
package uart_arb_pkg;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_START = 4'b0010;
    localparam logic [3:0] ST_WAIT  = 4'b0100;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_WAIT  = ST_WAIT
    } arb_state_t;

    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 16;

    function automatic bit n_req_in_range(input int n);
        return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the producer-side request/ack signals and the UART_TX
//   tx_data/tx_ready/tx_done handshake for the arbiter.
//   req_lock exists only when UART_ARB_LOCK_EN is defined.
// Signals:
//   req, req_data, req_lock : from the producers
//   req_ack, grant_id, busy : to the producers
//   tx_data, tx_ready       : to UART_TX
//   tx_done                 : from UART_TX (high = UART idle)
// Modports:
//   master : arbiter side
//   slave  : producers + UART side
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
    logic [N_REQ-1:0]        req_lock;
`endif
    logic [N_REQ-1:0]        req_ack;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_ready;
    logic                    tx_done;

`ifdef UART_ARB_LOCK_EN
    modport master (
        input  req, req_data, req_lock, tx_done,
        output req_ack, grant_id, busy, tx_data, tx_ready
    );
    modport slave (
        output req, req_data, req_lock, tx_done,
        input  req_ack, grant_id, busy, tx_data, tx_ready
    );
`else
    modport master (
        input  req, req_data, tx_done,
        output req_ack, grant_id, busy, tx_data, tx_ready
    );
    modport slave (
        output req, req_data, tx_done,
        input  req_ack, grant_id, busy, tx_data, tx_ready
    );
`endif

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational round-robin picker. Scans req starting at ptr+1 and
//   wrapping modulo N_REQ; the requester at ptr itself is checked last.
// Ports:
//   req   in  N_REQ : request vector
//   ptr   in  ID_W  : index of the last winner
//   valid out 1     : at least one request is set
//   idx   out ID_W  : winner index (0 when !valid)
//   grant out N_REQ : one-hot winner (0 when !valid)
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  idx,
    output logic [N_REQ-1:0] grant
);

    logic [ID_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART_TX between N_REQ byte producers with round-robin
//   arbitration. One UART transfer per acknowledged byte; bytes from
//   different producers never interleave.
//   Optional feature macro: UART_ARB_LOCK_EN (packet lock via req_lock).
// Ports:
//   clock  in : system clock (UART_TX domain)
//   reset  in : synchronous, active-low
//   bus       : uart_tx_arbiter_if.master
//               req/req_data/req_lock in, req_ack/grant_id/busy out,
//               tx_data/tx_ready out, tx_done in
//   All outputs are registered.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_arbiter_if.master bus
);

    localparam int ID_W = $clog2(N_REQ);

    if (!n_req_in_range(N_REQ)) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ out of range 2..16");
    end

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N_REQ-1:0]  pick_req;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    logic [N_REQ-1:0]  pick_grant;
    logic [DATA_W-1:0] pick_byte;

`ifdef UART_ARB_LOCK_EN
    // Set when a locked requester finishes a byte; while it stays set and
    // that requester keeps req_lock high, only it may win.
    logic lock_q, lock_d;
    logic hold_active;

    assign hold_active = lock_q && bus.req_lock[grant_q];
    assign pick_req    = hold_active
                       ? (bus.req & ({{(N_REQ-1){1'b0}}, 1'b1} << grant_q))
                       : bus.req;
`else
    assign pick_req = bus.req;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx),
        .grant (pick_grant)
    );

    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_byte = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        data_d  = data_q;
`ifdef UART_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                if (!bus.req_lock[grant_q]) begin
                    lock_d = 1'b0;
                end
`endif
                // Only arbitrate when the UART reports idle.
                if (bus.tx_done && pick_valid) begin
                    data_d  = pick_byte;
                    ack_d   = pick_grant;
                    grant_d = pick_idx;
                    ptr_d   = pick_idx;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                // tx_done low means UART_TX has taken the byte.
                if (!bus.tx_done) begin
                    ready_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = bus.req_lock[grant_q];
`endif
                end
            end
            default: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ack_q   <= '0;
            grant_q <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            data_q  <= data_d;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign bus.req_ack  = ack_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.tx_data  = data_q;
    assign bus.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with a behavioural UART_TX model
//   (clock_div 217, 10 bit times per byte) and a cycle-level reference
//   model of the arbiter's observable behaviour. Lock scenario is built
//   only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int CLK_DIV = 217;
    localparam int BYTE_T  = 10 * CLK_DIV;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // UART_TX model: takes a byte when idle and tx_ready is high, then
    // stays busy for one frame time.
    logic       uart_idle = 1'b1;
    logic       force_low = 1'b0;
    int         uart_cnt  = 0;
    logic [7:0] line_q[$];

    assign bus.tx_done = uart_idle & ~force_low;

    always @(negedge clock) begin
        if (uart_cnt > 0) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) uart_idle = 1'b1;
        end else if (bus.tx_done && bus.tx_ready) begin
            line_q.push_back(bus.tx_data);
            uart_idle = 1'b0;
            uart_cnt  = BYTE_T;
        end
    end

    // Reference model: inputs are stable at posedge (driven at negedge).
    int         m_ph   = 0;  // 0 idle, 1 offering byte, 2 byte in flight
    logic [N-1:0] m_ack = '0;
    int         m_gid  = 0;
    int         m_ptr  = N - 1;
    logic       m_busy = 1'b0;
    logic       m_rdy  = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_hold = 1'b0;

    initial begin
        logic [N-1:0]    rq, eff, lk;
        logic [N*DW-1:0] rd;
        logic            dn, rs;
        int              w;
        forever begin
            @(posedge clock);
            rs = reset; rq = bus.req; rd = bus.req_data; dn = bus.tx_done;
`ifdef UART_ARB_LOCK_EN
            lk = bus.req_lock;
`else
            lk = '0;
`endif
            if (!rs) begin
                m_ph = 0; m_ack = '0; m_gid = 0; m_ptr = N - 1;
                m_busy = 0; m_rdy = 0; m_data = '0; m_hold = 0;
            end else begin
                m_ack = '0;
                if (m_ph == 0) begin
                    eff = rq;
                    if (m_hold && lk[m_gid]) eff = rq & (N'(1) << m_gid);
                    if (!lk[m_gid]) m_hold = 0;
                    if (dn && eff != 0) begin
                        w = -1;
                        for (int k = 1; k <= N; k++) begin
                            int i;
                            i = (m_ptr + k) % N;
                            if (w < 0 && ((eff >> i) & N'(1)) != 0) w = i;
                        end
                        m_data = rd[w*DW +: DW];
                        m_ack  = N'(1) << w;
                        m_gid  = w;
                        m_ptr  = w;
                        m_rdy  = 1;
                        m_busy = 1;
                        m_ph   = 1;
                    end
                end else if (m_ph == 1) begin
                    if (!dn) begin m_rdy = 0; m_ph = 2; end
                end else begin
                    if (dn) begin
                        m_busy = 0; m_ph = 0;
                        m_hold = lk[m_gid];
                    end
                end
            end
            #1;
            chk("cyc_req_ack",  32'(bus.req_ack),  32'(m_ack));
            chk("cyc_grant_id", 32'(bus.grant_id), 32'(m_gid));
            chk("cyc_busy",     32'(bus.busy),     32'(m_busy));
            chk("cyc_tx_data",  32'(bus.tx_data),  32'(m_data));
            chk("cyc_tx_ready", 32'(bus.tx_ready), 32'(m_rdy));
        end
    end

    task automatic set_byte(input int i, input logic [7:0] v);
        bus.req_data[i*DW +: DW] = v;
    endtask

    task automatic wait_ack(input int budget, input string nm, output logic [N-1:0] a);
        a = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (bus.req_ack != '0) begin
                a = bus.req_ack;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL %s: no req_ack within %0d cycles", nm, budget);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (!bus.busy) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL %s: busy still high after %0d cycles", nm, budget);
    endtask

    task automatic chk_line(input string nm, input int idx, input logic [7:0] exp);
        if (line_q.size() > idx) chk(nm, 32'(line_q[idx]), 32'(exp));
        else chk(nm, 32'hDEAD, 32'(exp));
    endtask

    logic [N-1:0] a;
    int           gids[5];
    logic [7:0]   datas[5];
    logic [7:0]   exp_seq[5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30};
    int           exp_gid[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
`ifdef UART_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        repeat (3) @(negedge clock);
        chk("rst_req_ack",  32'(bus.req_ack), 0);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 0);
        reset = 1'b1;

        // Single requester, byte 0x41.
        @(negedge clock);
        set_byte(0, 8'h41);
        bus.req = 4'b0001;
        @(negedge clock);
        chk("t1_ack",     32'(bus.req_ack), 32'h1);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h41);
        chk("t1_busy",    32'(bus.busy), 1);
        bus.req = '0;
        repeat (100) @(negedge clock);
        chk("t1_busy_inflight", 32'(bus.busy), 1);
        wait_idle(BYTE_T + 20, "t1_idle");
        chk("t1_line_n", 32'(line_q.size()), 1);
        chk_line("t1_line0", 0, 8'h41);

        // All four requesting: round robin 0,1,2,3,0.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        line_q.delete();
        for (int i = 0; i < N; i++) set_byte(i, 8'(8'h30 + i));
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(BYTE_T + 20, "t2_ack", a);
            gids[j]  = int'(bus.grant_id);
            datas[j] = bus.tx_data;
            if (j == 4) bus.req = '0;
        end
        wait_idle(BYTE_T + 20, "t2_idle");
        for (int j = 0; j < 5; j++) begin
            chk("t2_grant_id", 32'(gids[j]), 32'(exp_gid[j]));
            chk("t2_tx_data", 32'(datas[j]), 32'(exp_seq[j]));
            chk_line("t2_line", j, exp_seq[j]);
        end

        // UART reports busy: no arbitration.
        line_q.delete();
        force_low = 1'b1;
        set_byte(2, 8'h55);
        bus.req = 4'b0100;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            chk("t3_no_ack",   32'(bus.req_ack), 0);
            chk("t3_no_ready", 32'(bus.tx_ready), 0);
        end
        force_low = 1'b0;
        wait_ack(3, "t3_ack", a);
        chk("t3_ack_vec", 32'(a), 32'h4);
        chk("t3_gid", 32'(bus.grant_id), 2);
        bus.req = '0;
        for (int c = 0; c < 10 && bus.tx_ready; c++) @(negedge clock);
        chk("t3_in_wait", 32'(bus.tx_ready), 0);

        // Reset while the byte is in flight.
        reset = 1'b0;
        @(negedge clock);
        chk("t4_ack",      32'(bus.req_ack), 0);
        chk("t4_gid",      32'(bus.grant_id), 0);
        chk("t4_busy",     32'(bus.busy), 0);
        chk("t4_tx_data",  32'(bus.tx_data), 0);
        chk("t4_tx_ready", 32'(bus.tx_ready), 0);
        reset = 1'b1;
        set_byte(0, 8'h11);
        set_byte(3, 8'h99);
        bus.req = 4'b1001;
        wait_ack(BYTE_T + 20, "t4_ack_after", a);
        chk("t4_ptr_wrap_ack", 32'(a), 32'h1);
        chk("t4_ptr_wrap_data", 32'(bus.tx_data), 32'h11);
        bus.req = '0;
        wait_idle(BYTE_T + 20, "t4_idle");
        chk("t4_line_n", 32'(line_q.size()), 2);
        chk_line("t4_line0", 0, 8'h55);
        chk_line("t4_line1", 1, 8'h11);

`ifdef UART_ARB_LOCK_EN
        // Requester 2 sends a locked 3-byte packet while 1 keeps asking.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        line_q.delete();
        set_byte(2, 8'h48);
        bus.req_lock = 4'b0100;
        bus.req = 4'b0100;
        wait_ack(BYTE_T + 20, "t5_ack0", a);
        chk("t5_ack0_vec", 32'(a), 32'h4);
        set_byte(2, 8'h49);
        set_byte(1, 8'h62);
        bus.req = 4'b0110;
        wait_ack(BYTE_T + 20, "t5_ack1", a);
        chk("t5_ack1_vec", 32'(a), 32'h4);
        set_byte(2, 8'h0A);
        wait_ack(BYTE_T + 20, "t5_ack2", a);
        chk("t5_ack2_vec", 32'(a), 32'h4);
        bus.req = 4'b0010;
        bus.req_lock = '0;
        wait_ack(BYTE_T + 20, "t5_ack3", a);
        chk("t5_ack3_vec", 32'(a), 32'h2);
        bus.req = '0;
        wait_idle(BYTE_T + 20, "t5_idle");
        chk_line("t5_line0", 0, 8'h48);
        chk_line("t5_line1", 1, 8'h49);
        chk_line("t5_line2", 2, 8'h0A);
        chk_line("t5_line3", 3, 8'h62);
`endif

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
